// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter granting one of NREQ cores access to a
// single memory port. Each transaction runs IDLE -> ACCESS -> RELEASE. The owner
// keeps its grant through RELEASE until it drops its request.
// Optional feature: define ARB_TIMEOUT_EN to abort an ACCESS that sees no
// mem_ack within TMO_CYC cycles. The abort pulses err and returns all-ones read
// data. Without the macro, err is tied low and no counter exists.
module mem_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic [NREQ-1:0]          err,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       last_owner_q, last_owner_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

`ifdef ARB_TIMEOUT_EN
  // The last ACCESS cycle allowed without an ack is cycle TMO_CYC. The counter
  // reads 0 in the first ACCESS cycle.
  localparam int              CNT_W   = (TMO_CYC > 1) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO_CYC - 1);

  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [NREQ-1:0]     err_q, err_d;
`endif

  // Round-robin pick. Scan upward from the requester after last_owner, wrap
  // around, and take the first set request bit.
  logic                pick_vld;
  logic [OW-1:0]       pick_idx;
  logic [OW-1:0]       cand_idx;
  int                  cand;

  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last_owner_q) + k) % NREQ;
      cand_idx = OW'(cand);
      if (!pick_vld && req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    done_d       = '0;
    rdata_d      = rdata_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef ARB_TIMEOUT_EN
    err_d        = '0;
    tmo_cnt_d    = tmo_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        grant_d  = '0;
        mem_en_d = 1'b0;
        if (pick_vld) begin
          owner_d           = pick_idx;
          grant_d[pick_idx] = 1'b1;
          mem_en_d          = 1'b1;
          mem_we_d          = we[pick_idx];
          mem_addr_d        = addr[pick_idx*ADDR_W +: ADDR_W];
          mem_wdata_d       = wdata[pick_idx*DATA_W +: DATA_W];
          state_d           = ACCESS;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt_d         = '0;
`endif
        end
      end

      ACCESS: begin
        // The memory-side registers are not touched here, so the request stays
        // stable until the ack. This holds even if the owner drops req.
        if (mem_ack) begin
          mem_en_d        = 1'b0;
          done_d[owner_q] = 1'b1;
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LIM) begin
          mem_en_d       = 1'b0;
          err_d[owner_q] = 1'b1;
          rdata_d        = '1;
          state_d        = RELEASE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      RELEASE: begin
        if (!req[owner_q]) begin
          grant_d      = '0;
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        mem_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset returns everything to a known idle state.
  // Requester 0 is the first to win after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(NREQ - 1);
      grant_q      <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      err_q        <= '0;
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef ARB_TIMEOUT_EN
      err_q        <= err_d;
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule
